// File: rtl/line_burst_planner.sv
// line_burst_planner: plans every AXI read burst of a video frame.
// The beat count comes from the active size. Descriptors (length, line/frame last)
// are issued over valid/ready, bursts in flight are tracked, and completion is flagged.
// Optional error reporting is enabled with `define LINE_BURST_PLANNER_ERR_EN.
module line_burst_planner #(
    parameter     MODE            = "ONCE",
    parameter int AXI_DSIZE       = 256,
    parameter int DSIZE           = 24,
    parameter int LSIZE           = 9,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OSIZE           = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             fsync,
    input  logic [15:0]      vactive,
    input  logic [15:0]      hactive,
    input  logic [LSIZE-1:0] burst_len,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [LSIZE-1:0] req_len,
    output logic             req_line_last,
    output logic             req_frame_last,
    input  logic             burst_done,
    output logic [OSIZE-1:0] outstanding,
    output logic             busy,
    output logic             frame_done,
    output logic             tail_status
`ifdef LINE_BURST_PLANNER_ERR_EN
    ,
    output logic             err,
    output logic [1:0]       err_code
`endif
);

    localparam bit LINE_MODE = (MODE == "LINE");
    localparam int SHIFT     = $clog2(AXI_DSIZE);

    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [15:0]      vactive_q, hactive_q;
    logic [LSIZE-1:0] blen_q;
    logic [31:0]      beats_q, remain;
    logic [15:0]      line_cnt;
    logic [OSIZE-1:0] outstanding_q;
    logic             frame_done_q;

    logic [31:0]      pixels;
    logic [39:0]      bits_w;
    logic [31:0]      beats_calc;
    logic [LSIZE-1:0] len;
    logic             in_issue, stream_end, last_line, accept, dec;

    // Beat count of one stream: ceil(pixels*DSIZE / AXI_DSIZE) via add-and-shift.
    always_comb begin
        pixels     = LINE_MODE ? 32'(hactive_q) : 32'(hactive_q) * 32'(vactive_q);
        bits_w     = 40'(pixels) * 40'(DSIZE);
        beats_calc = 32'((bits_w + 40'(AXI_DSIZE - 1)) >> SHIFT);
    end

    // Current descriptor fields, derived only from registers so they hold during a stall.
    always_comb begin
        in_issue   = (state == ISSUE);
        stream_end = (remain <= 32'(blen_q));
        len        = stream_end ? remain[LSIZE-1:0] : blen_q;
        last_line  = LINE_MODE ? (({1'b0, line_cnt} + 17'd1) >= {1'b0, vactive_q}) : 1'b1;
        req_valid      = in_issue && (outstanding_q < OSIZE'(MAX_OUTSTANDING));
        req_len        = in_issue ? len : '0;
        req_line_last  = in_issue && stream_end;
        req_frame_last = in_issue && stream_end && last_line;
        tail_status    = in_issue && (remain < 32'(blen_q));
        accept         = req_valid && req_ready;
        dec            = burst_done && (outstanding_q != '0);
        busy           = (state != IDLE);
        outstanding    = outstanding_q;
        frame_done     = frame_done_q;
    end

    // Next-state logic; fsync in any state (re)starts the frame calculation.
    always_comb begin
        state_nxt = state;
        if (fsync) begin
            state_nxt = CALC;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                CALC:    state_nxt = ((beats_calc == '0) || (LINE_MODE && (vactive_q == '0))) ? DONE : ISSUE;
                ISSUE:   if (accept && stream_end && last_line) state_nxt = DRAIN;
                DRAIN:   if (outstanding_q == '0) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Config latch and stream/line counters.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vactive_q <= '0;
            hactive_q <= '0;
            blen_q    <= '0;
            beats_q   <= '0;
            remain    <= '0;
            line_cnt  <= '0;
        end else if (fsync) begin
            vactive_q <= vactive;
            hactive_q <= hactive;
            blen_q    <= (burst_len == '0) ? LSIZE'(1) : burst_len;
        end else if (state == CALC) begin
            beats_q  <= beats_calc;
            remain   <= beats_calc;
            line_cnt <= '0;
        end else if (accept) begin
            if (stream_end && !last_line) begin
                line_cnt <= line_cnt + 16'd1;
                remain   <= beats_q;
            end else begin
                remain <= remain - 32'(len);
            end
        end
    end

    // Bursts in flight: accept adds one, a valid burst_done removes one.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            case ({accept, dec})
                2'b10:   outstanding_q <= outstanding_q + OSIZE'(1);
                2'b01:   outstanding_q <= outstanding_q - OSIZE'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // One-cycle completion pulse after DONE, suppressed if a restart arrives there.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) frame_done_q <= 1'b0;
        else        frame_done_q <= (state == DONE) && !fsync;
    end

`ifdef LINE_BURST_PLANNER_ERR_EN
    logic ev_underflow, ev_abort;
    assign ev_underflow = burst_done && (outstanding_q == '0);
    assign ev_abort     = fsync && (state != IDLE);

    // Per-event error pulse plus sticky cause bits.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            err      <= ev_underflow || ev_abort;
            err_code <= err_code | {ev_abort, ev_underflow};
        end
    end
`endif

endmodule

// File: tb/tb_line_burst_planner.sv
// Directed testbench for line_burst_planner: one LINE-mode and one ONCE-mode instance.
module tb_line_burst_planner;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    // LINE-mode instance signals
    logic        l_fsync = 0, l_req_ready = 0, l_burst_done = 0;
    logic [15:0] l_vactive = 0, l_hactive = 0;
    logic [8:0]  l_burst_len = 0, l_req_len;
    logic        l_req_valid, l_req_line_last, l_req_frame_last, l_busy, l_frame_done, l_tail_status;
    logic [2:0]  l_outstanding;

    // ONCE-mode instance signals
    logic        o_fsync = 0, o_req_ready = 0, o_burst_done = 0;
    logic [15:0] o_vactive = 0, o_hactive = 0;
    logic [8:0]  o_burst_len = 0, o_req_len;
    logic        o_req_valid, o_req_line_last, o_req_frame_last, o_busy, o_frame_done, o_tail_status;
    logic [2:0]  o_outstanding;
`ifdef LINE_BURST_PLANNER_ERR_EN
    logic        l_err, o_err;
    logic [1:0]  l_err_code, o_err_code;
`endif

    int checks = 0;
    int errors = 0;

    // Per-frame statistics gathered by runFrame
    int         n_desc, n_fl, fl_idx, n_tail, n_fd;
    logic [8:0] first_len, last_len;

    line_burst_planner #(.MODE("LINE")) u_line (
        .clock(clock), .rst_n(rst_n), .fsync(l_fsync), .vactive(l_vactive), .hactive(l_hactive),
        .burst_len(l_burst_len), .req_valid(l_req_valid), .req_ready(l_req_ready), .req_len(l_req_len),
        .req_line_last(l_req_line_last), .req_frame_last(l_req_frame_last), .burst_done(l_burst_done),
        .outstanding(l_outstanding), .busy(l_busy), .frame_done(l_frame_done), .tail_status(l_tail_status)
`ifdef LINE_BURST_PLANNER_ERR_EN
        , .err(l_err), .err_code(l_err_code)
`endif
    );

    line_burst_planner #(.MODE("ONCE")) u_once (
        .clock(clock), .rst_n(rst_n), .fsync(o_fsync), .vactive(o_vactive), .hactive(o_hactive),
        .burst_len(o_burst_len), .req_valid(o_req_valid), .req_ready(o_req_ready), .req_len(o_req_len),
        .req_line_last(o_req_line_last), .req_frame_last(o_req_frame_last), .burst_done(o_burst_done),
        .outstanding(o_outstanding), .busy(o_busy), .frame_done(o_frame_done), .tail_status(o_tail_status)
`ifdef LINE_BURST_PLANNER_ERR_EN
        , .err(o_err), .err_code(o_err_code)
`endif
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle fsync on the ONCE instance; returns in the CALC cycle
    task automatic applyStimulus(input logic [15:0] h, input logic [15:0] v, input logic [8:0] bl);
        o_fsync = 1; o_hactive = h; o_vactive = v; o_burst_len = bl;
        tick();
        o_fsync = 0;
    endtask

    // Run the ONCE instance to frame_done with ready high and burst_done one cycle after each accept
    task automatic runFrame(input int budget);
        bit acc_prev, finished;
        acc_prev = 0; finished = 0;
        n_desc = 0; n_fl = 0; fl_idx = 0; n_tail = 0; n_fd = 0; first_len = 0; last_len = 0;
        for (int c = 0; c < budget && !finished; c++) begin
            o_burst_done = acc_prev;
            acc_prev = o_req_valid && o_req_ready;
            if (acc_prev) begin
                n_desc++;
                if (n_desc == 1) first_len = o_req_len;
                last_len = o_req_len;
                if (o_req_frame_last) begin n_fl++; fl_idx = n_desc; end
                if (o_tail_status) n_tail++;
            end
            if (o_frame_done) begin n_fd++; finished = 1; end
            tick();
        end
        o_burst_done = 0;
        checkOutput("frame_budget", 32'(finished), 1);
    endtask

    initial begin
        int exp_len [6];
        bit exp_ll  [6];
        bit exp_fl  [6];
        bit exp_tl  [6];
        int got_len [6];
        bit got_ll  [6];
        bit got_fl  [6];
        bit got_tl  [6];
        int idx, fd_cnt, accepts;
        bit acc_prev;

        exp_len = '{64, 64, 52, 64, 64, 52};
        exp_ll  = '{0, 0, 1, 0, 0, 1};
        exp_fl  = '{0, 0, 0, 0, 0, 1};
        exp_tl  = '{0, 0, 1, 0, 0, 1};

        // ---------------- reset ----------------
        tick(); tick();
        checkOutput("rst_req_valid", 32'(o_req_valid), 0);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_outstanding", 32'(o_outstanding), 0);
        checkOutput("rst_frame_done", 32'(o_frame_done), 0);
        checkOutput("rst_req_len", 32'(o_req_len), 0);
        checkOutput("rst_line_busy", 32'(l_busy), 0);
`ifdef LINE_BURST_PLANNER_ERR_EN
        checkOutput("rst_err_code", 32'(o_err_code), 0);
`endif
        rst_n = 1;
        tick();

        // ---------------- LINE 1920x2, burst 64 ----------------
        l_fsync = 1; l_hactive = 1920; l_vactive = 2; l_burst_len = 64; l_req_ready = 1;
        tick();
        l_fsync = 0;
        idx = 0; fd_cnt = 0; acc_prev = 0;
        for (int c = 0; c < 40; c++) begin
            l_burst_done = acc_prev;
            acc_prev = l_req_valid && l_req_ready;
            if (acc_prev) begin
                if (idx < 6) begin
                    got_len[idx] = int'(l_req_len);
                    got_ll[idx]  = l_req_line_last;
                    got_fl[idx]  = l_req_frame_last;
                    got_tl[idx]  = l_tail_status;
                end
                idx++;
            end
            if (l_frame_done) fd_cnt++;
            tick();
        end
        l_burst_done = 0;
        checkOutput("line_desc_count", 32'(idx), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("line_len%0d", i), 32'(got_len[i]), 32'(exp_len[i]));
            checkOutput($sformatf("line_ll%0d", i), 32'(got_ll[i]), 32'(exp_ll[i]));
            checkOutput($sformatf("line_fl%0d", i), 32'(got_fl[i]), 32'(exp_fl[i]));
            checkOutput($sformatf("line_tail%0d", i), 32'(got_tl[i]), 32'(exp_tl[i]));
        end
        checkOutput("line_frame_done_count", 32'(fd_cnt), 1);
        checkOutput("line_end_outstanding", 32'(l_outstanding), 0);
        checkOutput("line_end_busy", 32'(l_busy), 0);

        // ---------------- rounding 100x1, burst 8 ----------------
        o_req_ready = 1;
        applyStimulus(100, 1, 8);
        checkOutput("lat_n1_valid", 32'(o_req_valid), 0);
        checkOutput("lat_n1_busy", 32'(o_busy), 1);
        tick();
        checkOutput("lat_n2_valid", 32'(o_req_valid), 1);
        checkOutput("lat_n2_len", 32'(o_req_len), 8);
        runFrame(50);
        checkOutput("round_ndesc", 32'(n_desc), 2);
        checkOutput("round_first", 32'(first_len), 8);
        checkOutput("round_last", 32'(last_len), 2);
        checkOutput("round_tail", 32'(n_tail), 1);
        checkOutput("round_fd", 32'(n_fd), 1);

        // ---------------- burst_done with nothing outstanding ----------------
        o_burst_done = 1;
        tick();
        o_burst_done = 0;
        checkOutput("underflow_outstanding", 32'(o_outstanding), 0);
`ifdef LINE_BURST_PLANNER_ERR_EN
        checkOutput("underflow_err", 32'(o_err), 1);
        checkOutput("underflow_code", 32'(o_err_code), 1);
`endif
        tick();
`ifdef LINE_BURST_PLANNER_ERR_EN
        checkOutput("underflow_err_pulse", 32'(o_err), 0);
`endif

        // ---------------- ONCE 1920x1080, burst 200 ----------------
        applyStimulus(1920, 1080, 200);
        runFrame(2000);
        checkOutput("big_ndesc", 32'(n_desc), 972);
        checkOutput("big_first", 32'(first_len), 200);
        checkOutput("big_last", 32'(last_len), 200);
        checkOutput("big_tail", 32'(n_tail), 0);
        checkOutput("big_fl_count", 32'(n_fl), 1);
        checkOutput("big_fl_idx", 32'(fl_idx), 972);
        checkOutput("big_fd", 32'(n_fd), 1);

        // ---------------- zero size ----------------
        applyStimulus(0, 5, 8);
        checkOutput("zero_n1_valid", 32'(o_req_valid), 0);
        checkOutput("zero_n1_fd", 32'(o_frame_done), 0);
        tick();
        checkOutput("zero_n2_valid", 32'(o_req_valid), 0);
        checkOutput("zero_n2_fd", 32'(o_frame_done), 0);
        checkOutput("zero_n2_busy", 32'(o_busy), 1);
        tick();
        checkOutput("zero_n3_fd", 32'(o_frame_done), 1);
        checkOutput("zero_n3_busy", 32'(o_busy), 0);
        tick();
        checkOutput("zero_n4_fd", 32'(o_frame_done), 0);

        // ---------------- burst_len 0 -> single beats ----------------
        applyStimulus(100, 1, 0);
        runFrame(100);
        checkOutput("bl0_ndesc", 32'(n_desc), 10);
        checkOutput("bl0_first", 32'(first_len), 1);
        checkOutput("bl0_last", 32'(last_len), 1);
        checkOutput("bl0_tail", 32'(n_tail), 0);

        // ---------------- back-pressure 1920x1, burst 8 ----------------
        applyStimulus(1920, 1, 8);
        tick();
        accepts = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_req_valid && o_req_ready) accepts++;
            tick();
        end
        checkOutput("bp_accepts", 32'(accepts), 4);
        checkOutput("bp_stall_valid", 32'(o_req_valid), 0);
        checkOutput("bp_stall_outstanding", 32'(o_outstanding), 4);
        o_burst_done = 1;
        tick();
        checkOutput("bp_resume_valid", 32'(o_req_valid), 1);
        checkOutput("bp_resume_outstanding", 32'(o_outstanding), 3);
        tick();
        o_burst_done = 0;
        checkOutput("bp_simul_outstanding", 32'(o_outstanding), 3);
        checkOutput("bp_simul_valid", 32'(o_req_valid), 1);
        tick();
        checkOutput("bp_refill_outstanding", 32'(o_outstanding), 4);
        checkOutput("bp_refill_valid", 32'(o_req_valid), 0);
        o_req_ready = 0;
        o_burst_done = 1;
        for (int c = 0; c < 4; c++) tick();
        o_burst_done = 0;
        o_req_ready = 1;
        checkOutput("bp_drained", 32'(o_outstanding), 0);
        runFrame(100);
        checkOutput("bp_rest_ndesc", 32'(n_desc), 17);
        checkOutput("bp_rest_last", 32'(last_len), 4);
        checkOutput("bp_rest_tail", 32'(n_tail), 1);
        checkOutput("bp_rest_fl_idx", 32'(fl_idx), 17);
        checkOutput("bp_rest_fd", 32'(n_fd), 1);

        // ---------------- abort after 2 of 3 descriptors ----------------
        o_burst_done = 0;
        applyStimulus(100, 1, 4);
        tick();
        checkOutput("abort_d1_len", 32'(o_req_len), 4);
        tick();
        tick();
        checkOutput("abort_d3_len", 32'(o_req_len), 2);
        checkOutput("abort_pre_outstanding", 32'(o_outstanding), 2);
        o_req_ready = 0;
        o_fsync = 1; o_hactive = 100; o_vactive = 1; o_burst_len = 8;
        tick();
        o_fsync = 0;
        checkOutput("abort_drop_valid", 32'(o_req_valid), 0);
        checkOutput("abort_outstanding", 32'(o_outstanding), 2);
        checkOutput("abort_busy", 32'(o_busy), 1);
        checkOutput("abort_no_fd", 32'(o_frame_done), 0);
`ifdef LINE_BURST_PLANNER_ERR_EN
        checkOutput("abort_err", 32'(o_err), 1);
        checkOutput("abort_code", 32'(o_err_code), 3);
`endif
        tick();
        checkOutput("restart_valid", 32'(o_req_valid), 1);
        checkOutput("restart_len", 32'(o_req_len), 8);
        checkOutput("restart_no_fd", 32'(o_frame_done), 0);
        o_burst_done = 1;
        tick();
        checkOutput("stale_drain1", 32'(o_outstanding), 1);
        tick();
        o_burst_done = 0;
        checkOutput("stale_drain0", 32'(o_outstanding), 0);
        checkOutput("stale_no_fd", 32'(o_frame_done), 0);
        o_req_ready = 1;
        runFrame(50);
        checkOutput("restart_ndesc", 32'(n_desc), 2);
        checkOutput("restart_first", 32'(first_len), 8);
        checkOutput("restart_last", 32'(last_len), 2);
        checkOutput("restart_fd", 32'(n_fd), 1);

        // ---------------- asynchronous reset mid-frame ----------------
        applyStimulus(1920, 1, 8);
        tick();
        tick();
        checkOutput("areset_pre_outstanding", 32'(o_outstanding), 1);
        #2;
        rst_n = 0;
        #1;
        checkOutput("areset_valid", 32'(o_req_valid), 0);
        checkOutput("areset_busy", 32'(o_busy), 0);
        checkOutput("areset_outstanding", 32'(o_outstanding), 0);
        checkOutput("areset_len", 32'(o_req_len), 0);
        tick();
        rst_n = 1;
        tick();
        checkOutput("areset_idle", 32'(o_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
